// File: rtl/chunked_add_seq_if.sv
// Operand/result handshake bundle for chunked_add_seq.
// The master drives operands and out_ready; the slave (the adder) drives results.
interface chunked_add_seq_if #(
  parameter int unsigned N_WIDTH  = 4,
  parameter int unsigned N_CHUNKS = 4
);
  localparam int unsigned TOTAL_W = N_WIDTH * N_CHUNKS;

  logic               in_valid;
  logic               in_ready;
  logic [TOTAL_W-1:0] a;
  logic [TOTAL_W-1:0] b;
  logic               c_in;
  logic               out_valid;
  logic               out_ready;
  logic [TOTAL_W-1:0] sum;
  logic               c_out;
  logic               ovf;
  logic               busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );
endinterface

// File: rtl/chunked_add_seq.sv
// Wide adder that time-multiplexes one N_WIDTH-bit ripple adder over N_CHUNKS
// cycles, LSB chunk first, with the inter-chunk carry held in a register.

// Combinational N_WIDTH-bit ripple-carry adder.
module ripple_adder #(
  parameter int unsigned N_WIDTH = 4
) (
  input  logic [N_WIDTH-1:0] a,
  input  logic [N_WIDTH-1:0] b,
  input  logic               c_in,
  output logic [N_WIDTH-1:0] sum,
  output logic               c_out
);
  logic [N_WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = c_in;
    for (int i = 0; i < int'(N_WIDTH); i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    c_out = carry[N_WIDTH];
  end
endmodule

module chunked_add_seq #(
  parameter int unsigned N_WIDTH  = 4,
  parameter int unsigned N_CHUNKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  chunked_add_seq_if.slave   bus
);
  localparam int unsigned TOTAL_W  = N_WIDTH * N_CHUNKS;
  localparam int unsigned IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int unsigned MSB      = TOTAL_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [TOTAL_W-1:0] a_q, a_d;
  logic [TOTAL_W-1:0] b_q, b_d;
  logic [TOTAL_W-1:0] sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [N_WIDTH-1:0] add_a;
  logic [N_WIDTH-1:0] add_b;
  logic [N_WIDTH-1:0] add_sum;
  logic               add_cout;

  // Present the current chunk of the captured operands to the shared adder.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < int'(N_CHUNKS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a = a_q[i*N_WIDTH +: N_WIDTH];
        add_b = b_q[i*N_WIDTH +: N_WIDTH];
      end
    end
  end

  ripple_adder #(
    .N_WIDTH (N_WIDTH)
  ) u_adder (
    .a     (add_a),
    .b     (add_b),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Next-state and next-register values.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < int'(N_CHUNKS); i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*N_WIDTH +: N_WIDTH] = add_sum;
          end
        end
        carry_d = add_cout;
        if (idx_q == LAST_IDX) begin
          // Top chunk: its adder MSB is the MSB of the final sum.
          c_out_d = add_cout;
          ovf_d   = (a_q[MSB] == b_q[MSB]) && (add_sum[N_WIDTH-1] != a_q[MSB]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_chunked_add_seq.sv
// Self-checking bench for chunked_add_seq: vector table, directed corner cases,
// and scoreboarded random runs on three parameterisations.
module tb_chunked_add_seq;
  typedef struct {
    logic [31:0] sum;
    logic        c_out;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  logic clk;
  logic rst_n;
  logic rst_s;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q_m[$];
  exp_t q_1[$];
  exp_t q_2[$];

  logic s1_done = 1'b0;
  logic s2_done = 1'b0;

  chunked_add_seq_if #(.N_WIDTH(4), .N_CHUNKS(4)) m_if ();
  chunked_add_seq_if #(.N_WIDTH(4), .N_CHUNKS(1)) s1_if ();
  chunked_add_seq_if #(.N_WIDTH(8), .N_CHUNKS(3)) s2_if ();

  chunked_add_seq #(.N_WIDTH(4), .N_CHUNKS(4)) dut_m  (.clk(clk), .rst_n(rst_n), .bus(m_if));
  chunked_add_seq #(.N_WIDTH(4), .N_CHUNKS(1)) dut_s1 (.clk(clk), .rst_n(rst_s), .bus(s1_if));
  chunked_add_seq #(.N_WIDTH(8), .N_CHUNKS(3)) dut_s2 (.clk(clk), .rst_n(rst_s), .bus(s2_if));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, detail);
  endtask

  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci);
    exp_t        e;
    logic [32:0] full;
    logic [31:0] mask;
    full    = {1'b0, a} + {1'b0, b} + 33'(ci);
    mask    = (32'd1 << w) - 32'd1;
    e.sum   = full[31:0] & mask;
    e.c_out = full[w];
    e.ovf   = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic [31:0] s, input logic co,
                     input logic ov);
    check(nm, (s == e.sum) && (co == e.c_out) && (ov == e.ovf),
          $sformatf("got sum=%h c_out=%b ovf=%b, want sum=%h c_out=%b ovf=%b",
                    s, co, ov, e.sum, e.c_out, e.ovf));
  endtask

  // Result monitors: a result is consumed at the edge following a negedge
  // where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && m_if.out_valid && m_if.out_ready) begin
      if (q_m.size() == 0) check("m_unexpected", 1'b0, $sformatf("sum=%h with empty queue", m_if.sum));
      else cmp("m_result", q_m.pop_front(), 32'(m_if.sum), m_if.c_out, m_if.ovf);
    end
  end

  always @(negedge clk) begin
    if (rst_s && s1_if.out_valid && s1_if.out_ready) begin
      if (q_1.size() == 0) check("s1_unexpected", 1'b0, $sformatf("sum=%h with empty queue", s1_if.sum));
      else cmp("s1_result", q_1.pop_front(), 32'(s1_if.sum), s1_if.c_out, s1_if.ovf);
    end
  end

  always @(negedge clk) begin
    if (rst_s && s2_if.out_valid && s2_if.out_ready) begin
      if (q_2.size() == 0) check("s2_unexpected", 1'b0, $sformatf("sum=%h with empty queue", s2_if.sum));
      else cmp("s2_result", q_2.pop_front(), 32'(s2_if.sum), s2_if.c_out, s2_if.ovf);
    end
  end

  // Drive operands and hold in_valid until accepted; in_valid is left high.
  task automatic send_m(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input exp_t e, input logic push, output int waited);
    logic acc;
    if (push) q_m.push_back(e);
    m_if.a        = av;
    m_if.b        = bv;
    m_if.c_in     = ci;
    m_if.in_valid = 1'b1;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = m_if.in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) check("m_accept", 1'b0, $sformatf("no accept within %0d cycles", waited));
  endtask

  task automatic wait_idle_m();
    int n;
    n = 0;
    while (!(m_if.in_ready && !m_if.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("m_idle", m_if.in_ready, $sformatf("in_ready=%b after %0d cycles, want 1", m_if.in_ready, n));
  endtask

  initial begin : main
    vec_t tbl[8];
    exp_t e;
    int   w;
    int   lat;
    int   n;
    logic rdy_seen;
    logic [15:0] av, bv;
    logic ci;

    tbl[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    rst_s = 1'b0;
    m_if.in_valid = 1'b0;  m_if.out_ready = 1'b1;  m_if.a = '0;  m_if.b = '0;  m_if.c_in = 1'b0;
    s1_if.in_valid = 1'b0; s1_if.out_ready = 1'b1; s1_if.a = '0; s1_if.b = '0; s1_if.c_in = 1'b0;
    s2_if.in_valid = 1'b0; s2_if.out_ready = 1'b1; s2_if.a = '0; s2_if.b = '0; s2_if.c_in = 1'b0;

    #12;
    check("reset_state", (m_if.sum == 16'h0) && !m_if.c_out && !m_if.ovf && !m_if.out_valid && !m_if.busy,
          $sformatf("sum=%h c_out=%b ovf=%b out_valid=%b busy=%b, want all 0",
                    m_if.sum, m_if.c_out, m_if.ovf, m_if.out_valid, m_if.busy));
    #1;
    rst_n = 1'b1;
    rst_s = 1'b1;
    #1;
    check("reset_in_ready", m_if.in_ready, $sformatf("in_ready=%b, want 1", m_if.in_ready));
    @(posedge clk);
    #1;

    // Vector table with latency and in_ready checks per operation.
    for (int i = 0; i < 8; i++) begin
      e.sum = 32'(tbl[i].sum); e.c_out = tbl[i].co; e.ovf = tbl[i].ov;
      send_m(tbl[i].a, tbl[i].b, tbl[i].ci, e, 1'b1, w);
      m_if.in_valid = 1'b0;
      lat = 0;
      rdy_seen = 1'b0;
      while (!m_if.out_valid && lat < 20) begin
        if (m_if.in_ready || !m_if.busy) rdy_seen = 1'b1;
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("latency_%0d", i), lat == 4, $sformatf("latency=%0d, want 4", lat));
      check($sformatf("busy_ready_%0d", i), !rdy_seen && !m_if.in_ready && m_if.busy,
            $sformatf("in_ready seen=%b now=%b busy=%b, want 0/0/1", rdy_seen, m_if.in_ready, m_if.busy));
      wait_idle_m();
    end

    // Backpressure: result held while new operands are offered and ignored.
    m_if.out_ready = 1'b0;
    e = model(16, 32'h5555, 32'h1111, 1'b0);
    send_m(16'h5555, 16'h1111, 1'b0, e, 1'b1, w);
    m_if.a = 16'hAAAA;
    m_if.b = 16'h0001;
    n = 0;
    while (!m_if.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold_%0d", k),
            m_if.out_valid && (m_if.sum == 16'h6666) && !m_if.c_out && !m_if.in_ready && m_if.busy,
            $sformatf("out_valid=%b sum=%h c_out=%b in_ready=%b busy=%b, want 1/6666/0/0/1",
                      m_if.out_valid, m_if.sum, m_if.c_out, m_if.in_ready, m_if.busy));
      @(posedge clk);
      #1;
    end
    q_m.push_back(model(16, 32'hAAAA, 32'h0001, 1'b0));
    m_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", !m_if.out_valid && m_if.in_ready,
          $sformatf("out_valid=%b in_ready=%b, want 0/1", m_if.out_valid, m_if.in_ready));
    @(posedge clk);
    #1;
    check("bp_accept", m_if.busy && !m_if.in_ready,
          $sformatf("busy=%b in_ready=%b, want 1/0", m_if.busy, m_if.in_ready));
    m_if.in_valid = 1'b0;
    wait_idle_m();

    // Asynchronous reset two cycles into ADD.
    send_m(16'h0F0F, 16'h0101, 1'b0, e, 1'b0, w);
    m_if.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_clear", (m_if.sum == 16'h0) && !m_if.c_out && !m_if.ovf && !m_if.out_valid && !m_if.busy,
          $sformatf("sum=%h c_out=%b ovf=%b out_valid=%b busy=%b, want all 0",
                    m_if.sum, m_if.c_out, m_if.ovf, m_if.out_valid, m_if.busy));
    #2;
    rst_n = 1'b1;
    #1;
    check("midreset_ready", m_if.in_ready && !m_if.busy,
          $sformatf("in_ready=%b busy=%b, want 1/0", m_if.in_ready, m_if.busy));
    @(posedge clk);
    #1;
    e.sum = 32'h0003; e.c_out = 1'b0; e.ovf = 1'b0;
    send_m(16'h0001, 16'h0002, 1'b0, e, 1'b1, w);
    m_if.in_valid = 1'b0;
    wait_idle_m();

    // Back-to-back random with in_valid and out_ready held high.
    for (int i = 0; i < 1000; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      ci = 1'($urandom);
      send_m(av, bv, ci, model(16, 32'(av), 32'(bv), ci), 1'b1, w);
      if (i > 0) check("m_spacing", w == 6, $sformatf("accept spacing=%0d, want 6", w));
    end
    m_if.in_valid = 1'b0;
    wait_idle_m();

    n = 0;
    while (!(s1_done && s2_done) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("sweep_done", s1_done && s2_done, $sformatf("s1_done=%b s2_done=%b, want 1/1", s1_done, s2_done));
    check("queues_empty", (q_m.size() == 0) && (q_1.size() == 0) && (q_2.size() == 0),
          $sformatf("pending m=%0d s1=%0d s2=%0d, want 0", q_m.size(), q_1.size(), q_2.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Random sweep: N_WIDTH=4, N_CHUNKS=1 (period 3).
  initial begin : sweep1
    logic [31:0] av, bv;
    logic ci, acc;
    int   w;
    wait (rst_s);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      av = $urandom & 32'hF;
      bv = $urandom & 32'hF;
      ci = 1'($urandom);
      q_1.push_back(model(4, av, bv, ci));
      s1_if.a = 4'(av); s1_if.b = 4'(bv); s1_if.c_in = ci; s1_if.in_valid = 1'b1;
      w = 0; acc = 1'b0;
      while (!acc && w < 50) begin
        @(negedge clk);
        acc = s1_if.in_ready;
        @(posedge clk);
        #1;
        w++;
      end
      if (i > 0) check("s1_spacing", acc && (w == 3), $sformatf("accept=%b spacing=%0d, want 1/3", acc, w));
    end
    s1_if.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    s1_done = 1'b1;
  end

  // Random sweep: N_WIDTH=8, N_CHUNKS=3 (period 5).
  initial begin : sweep2
    logic [31:0] av, bv;
    logic ci, acc;
    int   w;
    wait (rst_s);
    @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      av = $urandom & 32'hFF_FFFF;
      bv = $urandom & 32'hFF_FFFF;
      ci = 1'($urandom);
      q_2.push_back(model(24, av, bv, ci));
      s2_if.a = 24'(av); s2_if.b = 24'(bv); s2_if.c_in = ci; s2_if.in_valid = 1'b1;
      w = 0; acc = 1'b0;
      while (!acc && w < 50) begin
        @(negedge clk);
        acc = s2_if.in_ready;
        @(posedge clk);
        #1;
        w++;
      end
      if (i > 0) check("s2_spacing", acc && (w == 5), $sformatf("accept=%b spacing=%0d, want 1/5", acc, w));
    end
    s2_if.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    s2_done = 1'b1;
  end
endmodule
